sccb_init_sequencer: RTL

- Upstream command source for the SCCB master: walks a camera register-configuration ROM and issues one SCCB 3-phase write per entry.
- Drives the master's start / ip_addr / sub_addr / data_in / rw inputs and consumes its done output; handles inline millisecond delays, end-of-table and done-timeout.
- Lets the camera initialise from hardware without processor traffic; the APB path remains for run-time accesses.

---
 rtl/sccb_pkg.sv | 43 ++++
 rtl/sccb_ms_timer.sv | 56 +++++
 rtl/sccb_init_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Purpose: shared state encoding, ROM entry layout and timing helpers for the
//          SCCB init sequencer and its millisecond timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sccb_pkg;

  // Sequencer states. A single WAIT_DONE/GAP pair serves both the write and
  // the optional read-back; a phase flag in the top tells them apart.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_PWRUP      = 4'd1,
    S_FETCH      = 4'd2,
    S_FETCH_WAIT = 4'd3,
    S_DECODE     = 4'd4,
    S_ISSUE      = 4'd5,
    S_WAIT_DONE  = 4'd6,
    S_GAP        = 4'd7,
    S_DELAY      = 4'd8,
    S_ADVANCE    = 4'd9,
    S_FINISH     = 4'd10,
    S_ERROR      = 4'd11
  } seq_state_t;

  // ROM entry: {sub_addr[15:8], data[7:0]}.
  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG  = 8'hF0;
  localparam int          SUB_HI     = 15;
  localparam int          SUB_LO     = 8;
  localparam int          DAT_HI     = 7;
  localparam int          DAT_LO     = 0;

  // Largest millisecond count a delay entry can carry.
  localparam int          MS_MAX     = 255;

  // Clock cycles per millisecond; never below one so tiny test clocks still tick.
  function automatic int ms_div(input int clk_freq);
    int d;
    d = clk_freq / 1000;
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/sccb_ms_timer.sv
// Purpose: millisecond prescaler plus ms down-counter; load_i starts a count of
//          ms_i milliseconds, expired_o is high while the count is zero.
// Latency: expired_o rises exactly ms_i*CLK_FREQ/1000 cycles after the load edge;
//          a load of 0 reads expired on the very next cycle.
// Backpressure: none; load_i always wins over an in-progress count.
// Ports: PCLK, PRESET (async, active high), load_i, ms_i[7:0], expired_o.
module sccb_ms_timer #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       load_i,
  input  logic [7:0] ms_i,
  output logic       expired_o
);
  import sccb_pkg::*;

  localparam int               DIV      = ms_div(CLK_FREQ);
  localparam int               PRE_W    = $clog2(DIV) + 1;
  localparam int               MS_W     = $clog2(MS_MAX) + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q,  ms_d;

  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    if (load_i) begin
      pre_d = '0;
      ms_d  = MS_W'(ms_i);
    end else if (ms_q != '0) begin
      // Prescaler stops at PRE_LAST and rolls to zero as the ms count drops;
      // once the ms count is zero everything holds, so nothing wraps.
      if (pre_q >= PRE_LAST) begin
        pre_d = '0;
        ms_d  = ms_q - 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

  assign expired_o = (ms_q == '0);

endmodule

// File: rtl/sccb_init_sequencer.sv
// Purpose: walks a camera register ROM and issues one SCCB 3-phase write per
//          entry, with inline ms delays, end marker and done-timeout.
// Latency: PWRUP_MS ms after init_go to first fetch; 5 cycles from a GAP exit to
//          the next sccb_start; GAP_CYC idle cycles enforced between transactions.
// Backpressure: holds sccb_start until sccb_done; gives up after TIMEOUT_CYC.
// Optional: SCCB_READBACK_VERIFY_EN adds a read-back check after every write
//          (ports sccb_data_out, verify_err).
// Ports: PCLK/PRESET clock and async active-high reset; init_go start pulse;
//        rom_addr/rom_data synchronous ROM; sccb_* master command/handshake;
//        busy, init_done, init_err, err_index status.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         ROM_AW      = 6,
  parameter int         GAP_CYC     = 500,
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter int         PWRUP_MS    = 5
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              init_go,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [7:0]        sccb_ip_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_data_in,
  input  logic              sccb_done,
`ifdef SCCB_READBACK_VERIFY_EN
  input  logic [7:0]        sccb_data_out,
  output logic              verify_err,
`endif
  output logic              busy,
  output logic              init_done,
  output logic              init_err,
  output logic [ROM_AW-1:0] err_index
);

  // One cycle counter covers both the done-timeout and the inter-transaction
  // gap; it is sized for the larger of the two and saturates.
  localparam int               CYC_MAX   = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int               CYC_W     = $clog2(CYC_MAX) + 1;
  localparam logic [CYC_W-1:0] GAP_LAST  = CYC_W'(GAP_CYC - 1);
  localparam logic [CYC_W-1:0] TMO_LAST  = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [ROM_AW-1:0] IDX_LAST = '1;
  localparam logic [7:0]       PWRUP_MS8 = 8'(PWRUP_MS);

  seq_state_t        state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [ROM_AW-1:0] err_idx_q, err_idx_d;
  logic [7:0]        sub_q, sub_d;
  logic [7:0]        dat_q, dat_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic              tmr_load;
  logic [7:0]        tmr_ms;
  logic              tmr_expired;
  logic [7:0]        entry_sub;
  logic [7:0]        entry_dat;
`ifdef SCCB_READBACK_VERIFY_EN
  logic              rw_q, rw_d;
  logic              rd_q, rd_d;     // current transaction is the read-back
  logic              verr_q, verr_d;
`endif

  assign entry_sub = rom_data[SUB_HI:SUB_LO];
  assign entry_dat = rom_data[DAT_HI:DAT_LO];

  sccb_ms_timer #(
    .CLK_FREQ (CLK_FREQ)
  ) u_ms_timer (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .load_i    (tmr_load),
    .ms_i      (tmr_ms),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    sub_d     = sub_q;
    dat_d     = dat_q;
    start_d   = start_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_ms    = 8'd0;
`ifdef SCCB_READBACK_VERIFY_EN
    rw_d      = rw_q;
    rd_d      = rd_q;
    verr_d    = verr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (init_go) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          idx_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_ms   = PWRUP_MS8;
`ifdef SCCB_READBACK_VERIFY_EN
          verr_d   = 1'b0;
`endif
          state_d  = S_PWRUP;
        end
      end

      S_PWRUP: begin
        if (tmr_expired) state_d = S_FETCH;
      end

      // rom_addr is idx_q directly, so it is already on the bus in FETCH;
      // FETCH_WAIT covers the ROM's registered read.
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;

      S_DECODE: begin
        if (rom_data == END_MARKER) begin
          state_d = S_FINISH;
        end else if (entry_sub == DELAY_TAG) begin
          tmr_load = 1'b1;
          tmr_ms   = entry_dat;
          state_d  = S_DELAY;
        end else begin
          sub_d   = entry_sub;
          dat_d   = entry_dat;
`ifdef SCCB_READBACK_VERIFY_EN
          rw_d    = 1'b0;
          rd_d    = 1'b0;
`endif
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (sccb_done) begin
          start_d = 1'b0;
          state_d = S_GAP;
`ifdef SCCB_READBACK_VERIFY_EN
          // A read-back mismatch is recorded but the table keeps going.
          if (rd_q && (sccb_data_out != dat_q)) begin
            verr_d    = 1'b1;
            err_idx_d = idx_q;
          end
`endif
        end else if (cyc_q >= TMO_LAST) begin
          start_d = 1'b0;
          state_d = S_ERROR;
        end
      end

      // The master's done must have fallen too, so a level-style done can
      // never be mistaken for the next transaction's completion.
      S_GAP: begin
        if (!sccb_done && (cyc_q >= GAP_LAST)) begin
`ifdef SCCB_READBACK_VERIFY_EN
          if (!rd_q) begin
            rd_d    = 1'b1;
            rw_d    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            rd_d    = 1'b0;
            rw_d    = 1'b0;
            state_d = S_ADVANCE;
          end
`else
          state_d = S_ADVANCE;
`endif
        end
      end

      S_DELAY: begin
        if (tmr_expired) state_d = S_ADVANCE;
      end

      // A table without an end marker stops after its last slot rather than
      // wrapping back to entry 0.
      S_ADVANCE: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_ERROR: begin
        start_d   = 1'b0;
        err_d     = 1'b1;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
`ifdef SCCB_READBACK_VERIFY_EN
        rw_d      = 1'b0;
        rd_d      = 1'b0;
`endif
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every state change and otherwise saturates.
    cyc_inc = (cyc_q == '1) ? cyc_q : (cyc_q + 1'b1);
    cyc_d   = (state_d != state_q) ? '0 : cyc_inc;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      sub_q     <= '0;
      dat_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cyc_q     <= '0;
`ifdef SCCB_READBACK_VERIFY_EN
      rw_q      <= 1'b0;
      rd_q      <= 1'b0;
      verr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      sub_q     <= sub_d;
      dat_q     <= dat_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
`ifdef SCCB_READBACK_VERIFY_EN
      rw_q      <= rw_d;
      rd_q      <= rd_d;
      verr_q    <= verr_d;
`endif
    end
  end

  assign rom_addr      = idx_q;
  assign sccb_start    = start_q;
  assign sccb_sub_addr = sub_q;
  assign sccb_data_in  = dat_q;
  assign busy          = busy_q;
  assign init_done     = done_q;
  assign init_err      = err_q;
  assign err_index     = err_idx_q;
`ifdef SCCB_READBACK_VERIFY_EN
  assign sccb_rw       = rw_q;
  assign sccb_ip_addr  = DEV_ID | {7'd0, rw_q};
  assign verify_err    = verr_q;
`else
  assign sccb_rw       = 1'b0;
  assign sccb_ip_addr  = DEV_ID;
`endif

endmodule
